// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: bus typedefs, access-size and FSM enums.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_lsu_pkg;

  // Default RAM depth in 32-bit words.
  localparam int LSU_DEPTH = 128;

  typedef logic [31:0] MemBus;      // one RAM data word
  typedef logic [31:0] MemAddrBus;  // byte address from the execute stage

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response channel between the execute stage (master) and the LSU (slave).
// Latency: n/a (wiring only).
// Backpressure: req side via req_ready_o, rsp side via rsp_ready_i.
// Signals: req_valid_i/req_ready_o handshake with we/size/unsigned/addr/wdata;
//          rsp_valid_o/rsp_ready_i handshake with rdata/err.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic      req_valid_i;
  logic      req_ready_o;
  logic      req_we_i;
  logic [1:0] req_size_i;
  logic      req_unsigned_i;
  MemAddrBus req_addr_i;
  MemBus     req_wdata_i;

  logic      rsp_valid_o;
  logic      rsp_ready_i;
  MemBus     rsp_rdata_o;
  logic      rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering: merges store data into a RAM word and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_word (RAM word), i_size, i_offset (addr[1:0]), i_unsigned, i_wdata (store data);
//        o_merged (word to write back), o_load (load result aligned to bit 0).
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  MemBus      i_word,
  input  lsu_size_e  i_size,
  input  logic [1:0] i_offset,
  input  logic       i_unsigned,
  input  MemBus      i_wdata,
  output MemBus      o_merged,
  output MemBus      o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves live in lane addr[1]; addr[0] is already zero for aligned halves.
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_merged = i_word;
    o_load   = i_word;
    case (i_size)
      BYTE: begin
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      HALF: begin
        o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_merged = i_wdata;
        o_load   = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-addressed RAM; does read-modify-write for sub-word stores.
// Latency: accept cycle T -> rsp_valid_o at T+1 (error), T+2 (load, word store), T+3 (sub-word store).
// Backpressure: one request in flight; req_ready_o only in IDLE, RESP held until rsp_ready_i.
// Ports: clk, rst (sync, active high), bus (mem_lsu_if.slave), RAM read/write ports mem_*.
// Config: define MEM_LSU_MISALIGN_ERR_EN to report misaligned half/word accesses as errors;
//         otherwise the low address bits are forced to alignment and the access proceeds.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH  = LSU_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  mem_lsu_if.slave          bus,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  MemBus             mem_rdata_i,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output MemBus             mem_wdata_o,
  output logic              mem_we_o
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  lsu_state_e        r_state, w_next;
  logic              r_we, r_uns, r_err;
  lsu_size_e         r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_idx;
  MemBus             r_wdata, r_rd;

  lsu_size_e  w_size;
  logic       w_accept, w_oor, w_misalign, w_err;
  logic [1:0] w_off;
  MemBus      w_merged, w_load;

  assign w_size   = lsu_size_e'(bus.req_size_i);
  assign w_accept = bus.req_valid_i && (r_state == IDLE);
  assign w_oor    = {1'b0, bus.req_addr_i} >= ADDR_LIMIT;

`ifdef MEM_LSU_MISALIGN_ERR_EN
  assign w_misalign = ((w_size == HALF) && bus.req_addr_i[0]) ||
                      ((w_size == WORD) && (bus.req_addr_i[1:0] != 2'b00));
  assign w_off      = bus.req_addr_i[1:0];
`else
  // Misalignment is silently truncated to the natural boundary.
  assign w_misalign = 1'b0;
  assign w_off      = (w_size == WORD) ? 2'b00 :
                      (w_size == HALF) ? {bus.req_addr_i[1], 1'b0} :
                                         bus.req_addr_i[1:0];
`endif

  assign w_err = (w_size == RSVD) || w_misalign || w_oor;

  mem_lsu_lane u_lane (
    .i_word     (r_rd),
    .i_size     (r_size),
    .i_offset   (r_off),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= BYTE;
      r_off   <= 2'b00;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we_i;
        r_uns   <= bus.req_unsigned_i;
        r_err   <= w_err;
        r_size  <= w_size;
        r_off   <= w_off;
        r_idx   <= bus.req_addr_i[ADDR_W+1:2];
        r_wdata <= bus.req_wdata_i;
      end
      if (r_state == READ) begin
        r_rd <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_err_o   = 1'b0;
    bus.rsp_rdata_o = '0;
    mem_we_o        = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          if (w_err)                                  w_next = RESP;
          else if (bus.req_we_i && (w_size == WORD))  w_next = WRITE;
          else                                        w_next = READ;
        end
      end
      READ: begin
        w_next = r_we ? WRITE : RESP;
      end
      WRITE: begin
        // Gated by rst so a reset landing here abandons the store cleanly.
        mem_we_o = !rst;
        w_next   = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = r_err;
        bus.rsp_rdata_o = (r_we || r_err) ? '0 : w_load;
        if (bus.rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_raddr_o = r_idx;
  assign mem_waddr_o = r_idx;
  assign mem_wdata_o = w_merged;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit directly upstream of the word-addressed data RAM (32-bit words, 128 entries, combinational read, synchronous write, no byte enables).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Drives the RAM's read and write ports, performing read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data on a valid/ready response channel.

Parameters:
DEPTH, 128, number of 32-bit RAM words
ADDR_W, $clog2(DEPTH), RAM word-address width (7 at default)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
req_unsigned_i  in  1  load zero-extends when 1
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, low bytes used for sub-word
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned, out-of-range or reserved size
mem_raddr_o  out  ADDR_W  RAM read word address
mem_rdata_i  in  32  RAM read data (combinational)
mem_waddr_o  out  ADDR_W  RAM write word address
mem_wdata_o  out  32  RAM write data
mem_we_o  out  1  RAM write enable

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (synchronous, rst=1 at posedge): state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, internal latches cleared.
- mem_we_o is state==WRITE gated by !rst, so reset mid-operation abandons the request and no write occurs.
- req_ready_o=1 only in IDLE. On acceptance, latch we, size, unsigned, addr, wdata.
- Word index = addr[ADDR_W+1:2]. mem_raddr_o and mem_waddr_o always drive the latched index.
- Error conditions, checked at accept:
  - size=11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr >= DEPTH*4
- Transitions from IDLE:
  - error -> RESP with err=1, no RAM access
  - load -> READ
  - word store -> WRITE
  - byte/half store -> READ
- READ: register mem_rdata_i into rd_q. Load -> RESP. Sub-word store -> WRITE.
- WRITE: mem_wdata_o = wdata for word stores, else rd_q with the selected lane(s) replaced by wdata[7:0] or wdata[15:0] at addr[1:0] (half lane addr[1]). mem_we_o=1 for exactly this cycle. -> RESP.
- RESP: rsp_valid_o=1. rsp_rdata_o is the extracted byte/half/word from rd_q, shifted to bit 0, sign-extended unless unsigned; 0 for stores and errors. Hold all outputs stable until rsp_ready_i. On handshake -> IDLE.
- No new request is accepted in the handshake cycle; next acceptance is earliest the following cycle.
- Latency from accept edge T to rsp_valid_o:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3 (write committed at end of T+2)
- Back-to-back store then load to the same address returns the new data, since the write commits before RESP.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_ERR_EN.
- Defined: misaligned half/word accesses raise rsp_err_o with no RAM access, as above.
- Undefined: misalignment is not an error; addr[1:0] is forced to 00 for word and addr[0] to 0 for half, and the access proceeds normally. Reserved size and out-of-range still raise an error.

Decomposition:
- Shared package (defines.sv):
  - MemBus and MemAddrBus typedefs
  - lsu_size_e enum (BYTE, HALF, WORD, RSVD)
  - lsu_state_e enum
- One combinational sub-module, mem_lsu_lane:
  - inputs: word, size, offset, unsigned, store data
  - outputs: merged store word, extracted/extended load value

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> RAM[4]=0xDEADBEEF, mem_we_o high 1 cycle, rsp_rdata_o=0xDEADBEEF, err=0, load latency 2.
- Store byte 0x5A @0x13 over 0x11223344 -> RAM[4]=0x5A223344. Signed byte load @0x13 after storing 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load @0x12 of 0x8001xxxx -> signed 0xFFFF8001, unsigned 0x00008001.
- Word load @0x11 -> with macro: rsp_err_o=1, rdata=0, mem_we_o never high, latency 1; without macro: data of RAM[4].
- Store @0x200 (DEPTH=128) or size=11 -> err=1, no write. Hold rsp_ready_i=0 for 5 cycles -> rsp outputs stable and req_ready_o=0 throughout.
- Assert rst in the WRITE cycle of a byte store -> mem_we_o=0, RAM unchanged; next cycle state IDLE, req_ready_o=1, rsp_valid_o=0.
